add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arb_pkg.sv | 13 +
 rtl/adder_rca.sv | 23 ++
 rtl/add_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/add_arb_pkg.sv
// Shared types and default sizing for the arbitrated adder.
// Holds the response-register state encoding used by add_arbiter.
package add_arb_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/adder_rca.sv
// Combinational ripple-carry adder: {cout, z} = a + b.
module adder_rca #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z,
    output logic             cout
);

    logic [WIDTH:0] carry;

    always_comb begin
        carry    = '0;
        z        = '0;
        for (int i = 0; i < WIDTH; i++) begin
            z[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[WIDTH];
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one adder among N_REQ requesters; one result
// register that can drain and refill in the same cycle.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        rsp_valid,
    output logic [ID_W-1:0]             rsp_id,
    output logic [WIDTH-1:0]            rsp_z,
    output logic                        rsp_cout,
    input  logic                        rsp_ready,
    output logic [31:0]                 txn_count,
    output arb_state_e                  dbg_state
);

    arb_state_e       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  win_idx;
    logic             found;
    logic             grant_en;
    logic             accept;
    int               cand;
    logic [WIDTH-1:0] sum_z;
    logic             sum_cout;

    // Grant logic looks only at valids, pointer, state and rsp_ready so
    // operand values can never influence the handshake.
    always_comb begin
        grant_en  = !reset && ((state == EMPTY) || rsp_ready);
        found     = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = ID_W'(cand);
            end
        end
        req_ready = '0;
        if (grant_en && found) begin
            req_ready[win_idx] = 1'b1;
        end
        accept = grant_en && found;
    end

    adder_rca #(.WIDTH(WIDTH)) u_adder (
        .a    (req_a[win_idx]),
        .b    (req_b[win_idx]),
        .z    (sum_z),
        .cout (sum_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_z     <= '0;
            rsp_cout  <= 1'b0;
            rr_ptr    <= '0;
            txn_count <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                txn_count <= txn_count + 32'd1;
            end
            if (accept) begin
                state     <= HOLD;
                rsp_valid <= 1'b1;
                rsp_id    <= win_idx;
                rsp_z     <= sum_z;
                rsp_cout  <= sum_cout;
                rr_ptr    <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            end else if (rsp_ready) begin
                state     <= EMPTY;
                rsp_valid <= 1'b0;
            end
        end
    end

    assign dbg_state = state;

endmodule
